// File: rtl/imem_fetch_server_if.sv
// Fetch-stage instruction bus: request (byte PC) and response (8-byte window) handshakes.
interface imem_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_error;

    modport master (
        output req_valid, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_pc, resp_ready,
        output req_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/imem_fetch_server.sv
// Instruction-memory responder: returns the little-endian 8-byte window at a byte PC,
// assembling unaligned windows from two word reads. Includes a word-write load port.
module imem_fetch_server #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned WIDX_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_if.slave       bus,
    input  logic              load_en,
    input  logic [WIDX_W-1:0] load_addr,
    input  logic [63:0]       load_data
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_e;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    state_e              state_q, state_d;
    logic [WIDX_W-1:0]   w_q, w_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_error_q, resp_error_d;
    logic                resp_valid_q, resp_valid_d;

    logic                req_ready_c;
    logic [WIDX_W-1:0]   req_w_c;
    logic [OFF_W-1:0]    req_off_c;
    logic                req_err_c;
    logic [WIDX_W-1:0]   rd_idx_c;
    logic [DATA_W-1:0]   ram_rd_c;
    logic [DATA_W-1:0]   win_c;

    assign req_ready_c = (state_q == IDLE) && !rst;
    assign req_w_c     = bus.req_pc[WIDX_W+2:OFF_W];
    assign req_off_c   = bus.req_pc[OFF_W-1:0];

    // Out of range when the upper PC bits are set or the window runs past the last word.
    assign req_err_c = (bus.req_pc[DATA_W-1:WIDX_W+3] != '0)
                    || (32'(req_w_c) >= DEPTH_WORDS)
                    || ((req_off_c != '0) && ((32'(req_w_c) + 32'd1) >= DEPTH_WORDS));

    // RAM read port: word w in RD_LO, word w+1 in RD_HI; old data wins on a same-edge write.
    assign rd_idx_c = (state_q == RD_HI) ? WIDX_W'(w_q + 1'b1) : w_q;
    assign ram_rd_c = mem[rd_idx_c];
    assign win_c    = DATA_W'({ram_rd_c, lo_q} >> {off_q, 3'b000});

    always_ff @(posedge clk) begin
        if (load_en && (32'(load_addr) < DEPTH_WORDS)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        off_d        = off_q;
        lo_d         = lo_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    w_d   = req_w_c;
                    off_d = req_off_c;
                    if (req_err_c) begin
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                lo_d = ram_rd_c;
                if (off_q == '0) begin
                    resp_data_d  = ram_rd_c;
                    resp_error_d = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                resp_data_d  = win_c;
                resp_error_d = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= '0;
            off_q        <= '0;
            lo_q         <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            off_q        <= off_d;
            lo_q         <= lo_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_imem_fetch_server.sv
// Bench for imem_fetch_server: directed vector table, multi-cycle corner sequences,
// and random fetches checked against a byte-addressed memory model.
module tb_imem_fetch_server;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned WIDX_W = 9;
    localparam int unsigned NBYTES = DEPTH * 8;

    logic              clk;
    logic              rst;
    logic              load_en;
    logic [WIDX_W-1:0] load_addr;
    logic [63:0]       load_data;

    imem_fetch_if bus ();

    imem_fetch_server #(.DEPTH_WORDS(DEPTH), .WIDX_W(WIDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mbytes [NBYTES];

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [63:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = WIDX_W'(addr);
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
        for (int i = 0; i < 8; i++) mbytes[addr*8 + i] = data[8*i +: 8];
    endtask

    // Reference: a window is legal iff all 8 bytes lie inside memory.
    task automatic model(input logic [63:0] pc, output logic [63:0] d, output logic e, output int lat);
        logic [2:0] off;
        off = pc[2:0];
        e   = (pc > 64'(NBYTES - 8));
        d   = '0;
        if (e) begin
            lat = 1;
        end else begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = mbytes[int'(pc) + i];
            lat = (off == 3'd0) ? 2 : 3;
        end
    endtask

    // Issue one fetch, measure latency, stall hold cycles, then consume.
    task automatic fetch(input logic [63:0] pc, input int hold,
                         output logic [63:0] d, output logic e, output int lat);
        int g;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_pc     = pc;
        bus.resp_ready = 1'b0;
        g = 0;
        while (!bus.req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g == 10) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: req_ready stuck low, pc=%h", pc);
            bus.req_valid = 1'b0;
            d = '0; e = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = bus.resp_data;
        e = bus.resp_error;
        for (int s = 0; s < hold; s++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.resp_valid), 64'd1);
            chk("stall_data", bus.resp_data, d);
            chk("stall_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("post_valid", 64'(bus.resp_valid), 64'd0);
        chk("post_ready", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, ed, pc;
        logic        e, ee;
        int          lat, el, r;

        rst = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.req_valid = 1'b0; bus.req_pc = '0; bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_data", bus.resp_data, 64'd0);
        chk("rst_error", 64'(bus.resp_error), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);

        // Whole-memory preload happens while reset is held.
        for (int a = 0; a < int'(DEPTH); a++) load_word(a, {$urandom, $urandom});
        load_word(0,   64'h0807060504030201);
        load_word(1,   64'h100F0E0D0C0B0A09);
        load_word(510, 64'hA7A6A5A4A3A2A1A0);
        load_word(511, 64'hB7B6B5B4B3B2B1B0);

        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        vecs[0]  = '{64'd0,    64'h0807060504030201, 1'b0, 2};
        vecs[1]  = '{64'd3,    64'h0B0A090807060504, 1'b0, 3};
        vecs[2]  = '{64'd1,    64'h0908070605040302, 1'b0, 3};
        vecs[3]  = '{64'd7,    64'h0F0E0D0C0B0A0908, 1'b0, 3};
        vecs[4]  = '{64'd8,    64'h100F0E0D0C0B0A09, 1'b0, 2};
        vecs[5]  = '{64'd4088, 64'hB7B6B5B4B3B2B1B0, 1'b0, 2};
        vecs[6]  = '{64'd4081, 64'hB0A7A6A5A4A3A2A1, 1'b0, 3};
        vecs[7]  = '{64'd4089, 64'h0,                1'b1, 1};
        vecs[8]  = '{64'd4095, 64'h0,                1'b1, 1};
        vecs[9]  = '{64'h1_0000_0000, 64'h0,         1'b1, 1};
        vecs[10] = '{64'h8000_0000_0000_0000, 64'h0, 1'b1, 1};

        foreach (vecs[i]) begin
            fetch(vecs[i].pc, 0, d, e, lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].data);
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].err));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure: response held for 5 cycles.
        fetch(64'd0, 5, d, e, lat);
        chk("bp_data", d, 64'h0807060504030201);
        chk("bp_lat", 64'(lat), 64'd2);

        // Reset while in RD_HI aborts the fetch without a response.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 64'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 64'(bus.resp_valid), 64'd0);
        chk("abort_ready_in_rst", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        #1 chk("abort_ready", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        fetch(64'd0, 0, d, e, lat);
        chk("abort_refetch", d, 64'h0807060504030201);
        chk("abort_refetch_lat", 64'(lat), 64'd2);

        // Write to mem[0] on the RD_LO edge: old word is returned.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 64'd0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        load_en = 1'b1; load_addr = '0; load_data = 64'hFF;
        @(negedge clk);
        load_en = 1'b0;
        for (int i = 0; i < 8; i++) mbytes[i] = (i == 0) ? 8'hFF : 8'h00;
        chk("coll_valid", 64'(bus.resp_valid), 64'd1);
        chk("coll_old", bus.resp_data, 64'h0807060504030201);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        fetch(64'd0, 0, d, e, lat);
        chk("coll_new", d, 64'h00000000000000FF);
        fetch(64'd1, 0, d, e, lat);
        chk("coll_new_pc1", d, 64'h0900000000000000);

        // Random fetches with random loads mixed in.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0)
                load_word(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            r = int'($urandom_range(0, 9));
            if (r == 0)      pc = {32'($urandom_range(1, 255)), 32'($urandom)};
            else if (r < 4)  pc = 64'($urandom_range(4070, 4100));
            else             pc = 64'($urandom_range(0, NBYTES - 1));
            model(pc, ed, ee, el);
            fetch(pc, int'($urandom_range(0, 3)), d, e, lat);
            chk($sformatf("rnd%0d_data pc=%0h", n, pc), d, ed);
            chk($sformatf("rnd%0d_err pc=%0h", n, pc), 64'(e), 64'(ee));
            chk($sformatf("rnd%0d_lat pc=%0h", n, pc), 64'(lat), 64'(el));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
